// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default taps and single-step function for lfsr_gen
// Purpose: one place that defines what a single LFSR step is, so the RTL
//          step network and any reference model compute the same thing.
// Ports:   none (package).
package lfsr_pkg;

   typedef enum logic {
      LFSR_FIB = 1'b0,
      LFSR_GAL = 1'b1
   } lfsr_mode_e;

   // Maximal-length Fibonacci tap masks for common widths.
   localparam logic [3:0]  TAPS_4  = 4'hC;
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h80200003;

   // One single-step on a state right-aligned in 32 bits. Bits at and above
   // width must be zero on entry and are zero on exit.
   function automatic logic [31:0] lfsr_step(
      input logic [31:0] state,
      input logic [31:0] taps,
      input lfsr_mode_e  mode,
      input int unsigned width
   );
      logic [31:0] mask;
      logic [31:0] gmask;
      logic [31:0] shifted;
      logic        msb;
      // A shift by 32 yields 0, so the mask is all-ones for width = 32.
      mask    = (32'd1 << width) - 32'd1;
      shifted = (state << 1) & mask;
      msb     = |(state & (32'd1 << (width - 1)));
      if (mode == LFSR_FIB) begin
         return shifted | {31'd0, ^(state & taps)};
      end
      // Galois form of the same polynomial: the x^0 term is always present.
      gmask = ((taps << 1) | 32'd1) & mask;
      return shifted ^ (msb ? gmask : 32'd0);
   endfunction

endpackage

// File: rtl/lfsr_gen_step_net.sv
// rtl/lfsr_gen_step_net.sv - combinational STEPS-deep unrolled LFSR step chain
// Purpose: advances an LFSR state by STEPS single-steps in one cycle.
// Ports:   state_i - current state
//          next_o  - state after STEPS single-steps
module lfsr_gen_step_net
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter lfsr_mode_e       MODE  = LFSR_FIB,
   parameter int unsigned      STEPS = 1
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] chain [STEPS+1];

   assign chain[0] = state_i;

   for (genvar k = 0; k < STEPS; k++) begin : g_step
      assign chain[k+1] = WIDTH'(lfsr_step(32'(chain[k]), 32'(TAPS), MODE, WIDTH));
   end

   assign next_o = chain[STEPS];

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with load, lock-up guard and wrap detection
// Purpose: pattern/noise source; steps STEPS times per enabled cycle, reports
//          when the sequence returns to the last-loaded seed and how long it took.
// Ports:   clk       - rising-edge clock
//          rst_n     - asynchronous active-low reset
//          en        - advance state by STEPS single-steps
//          load      - load load_val (priority over en)
//          load_val  - seed to load; zero is rejected and SEED used instead
//          state_out - registered LFSR state
//          bit_out   - state_out[WIDTH-1]
//          wrap      - one-cycle pulse when state returns to the seed
//          period    - step count of the last completed wrap
//          lock_err  - one-cycle pulse when a zero load was rejected
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'h8001,
   parameter int unsigned      MODE  = 0,
   parameter int unsigned      STEPS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state_out,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             lock_err
);

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_gen: STEPS must be in 1..WIDTH");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
   end
   if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_gen: TAPS[WIDTH-1] must be set");
   end

   localparam lfsr_mode_e MODE_E = (MODE == 1) ? LFSR_GAL : LFSR_FIB;

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             lock_q, lock_d;
   logic [WIDTH-1:0] step_next;
   logic [WIDTH:0]   cnt_sum;

   lfsr_gen_step_net #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE_E),
      .STEPS (STEPS)
   ) u_step_net (
      .state_i (state_q),
      .next_o  (step_next)
   );

   // Step count including this cycle's steps; also the period if we wrap now.
   assign cnt_sum = cnt_q + (WIDTH+1)'(STEPS);

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      lock_d   = 1'b0;
      if (load) begin
         // Zero would lock the register up; fall back to SEED and flag it.
         if (load_val != '0) begin
            state_d = load_val;
            ref_d   = load_val;
         end else begin
            state_d = SEED;
            ref_d   = SEED;
            lock_d  = 1'b1;
         end
         cnt_d = '0;
      end else if (en) begin
         state_d = step_next;
         // Only the end-of-cycle state is compared against the seed.
         if (step_next == ref_q) begin
            wrap_d   = 1'b1;
            period_d = cnt_sum[WIDTH-1:0];
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SEED;
         ref_q    <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         wrap_q   <= wrap_d;
         lock_q   <= lock_d;
      end
   end

   assign state_out = state_q;
   assign bit_out   = state_q[WIDTH-1];
   assign wrap      = wrap_q;
   assign period    = period_q;
   assign lock_err  = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen
module tb_lfsr_gen;
   import lfsr_pkg::*;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   // Default Fibonacci instance.
   logic        en_f, load_f;
   logic [15:0] lv_f, st_f, per_f;
   logic        bit_f, wrap_f, lock_f;
   // Galois instance.
   logic        en_g, load_g;
   logic [15:0] lv_g, st_g, per_g;
   logic        bit_g, wrap_g, lock_g;
   // STEPS = 2 instance.
   logic        en_s, load_s;
   logic [15:0] lv_s, st_s, per_s;
   logic        bit_s, wrap_s, lock_s;
   // 4-bit instance.
   logic        en_w, load_w;
   logic [3:0]  lv_w, st_w, per_w;
   logic        bit_w, wrap_w, lock_w;

   lfsr_gen u_fib (
      .clk(clk), .rst_n(rst_n), .en(en_f), .load(load_f), .load_val(lv_f),
      .state_out(st_f), .bit_out(bit_f), .wrap(wrap_f), .period(per_f), .lock_err(lock_f)
   );

   lfsr_gen #(.MODE(1)) u_gal (
      .clk(clk), .rst_n(rst_n), .en(en_g), .load(load_g), .load_val(lv_g),
      .state_out(st_g), .bit_out(bit_g), .wrap(wrap_g), .period(per_g), .lock_err(lock_g)
   );

   lfsr_gen #(.STEPS(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .en(en_s), .load(load_s), .load_val(lv_s),
      .state_out(st_s), .bit_out(bit_s), .wrap(wrap_s), .period(per_s), .lock_err(lock_s)
   );

   lfsr_gen #(.WIDTH(4), .TAPS(TAPS_4), .SEED(4'h1)) u_w4 (
      .clk(clk), .rst_n(rst_n), .en(en_w), .load(load_w), .load_val(lv_w),
      .state_out(st_w), .bit_out(bit_w), .wrap(wrap_w), .period(per_w), .lock_err(lock_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      if (st_f !== 16'h8001 || wrap_f !== 1'b0 || per_f !== 16'h0 || lock_f !== 1'b0) begin
         $display("FAIL reset_fib state=%h wrap=%b period=%h lock=%b want 8001 0 0000 0", st_f, wrap_f, per_f, lock_f);
      end else pass_cnt++;
      total_cnt++;
      if (st_g !== 16'h8001 || st_s !== 16'h8001) begin
         $display("FAIL reset_gal_s2 gal=%h s2=%h want 8001 8001", st_g, st_s);
      end else pass_cnt++;
      total_cnt++;
      if (st_w !== 4'h1 || per_w !== 4'h0 || wrap_w !== 1'b0) begin
         $display("FAIL reset_w4 state=%h period=%h wrap=%b want 1 0 0", st_w, per_w, wrap_w);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_fib();
      logic [15:0] exp_st [3];
      logic        exp_bit [3];
      exp_st  = '{16'h8001, 16'h0003, 16'h0006};
      exp_bit = '{1'b1, 1'b0, 1'b0};
      en_f = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         if (st_f !== exp_st[i] || bit_f !== exp_bit[i]) begin
            $display("FAIL fib_seq[%0d] state=%h bit=%b want %h %b", i, st_f, bit_f, exp_st[i], exp_bit[i]);
         end else pass_cnt++;
         total_cnt++;
      end
      en_f = 1'b0;
      @(negedge clk);
      if (st_f !== 16'h0006) begin
         $display("FAIL fib_hold state=%h want 0006", st_f);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_galois();
      logic [15:0] exp_st [3];
      exp_st = '{16'h8001, 16'h6803, 16'hD006};
      en_g = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         if (st_g !== exp_st[i]) begin
            $display("FAIL gal_seq[%0d] state=%h want %h", i, st_g, exp_st[i]);
         end else pass_cnt++;
         total_cnt++;
      end
      en_g = 1'b0;
   endtask

   task automatic test_steps2();
      en_s = 1'b1;
      @(negedge clk);
      en_s = 1'b0;
      if (st_s !== 16'h0006) begin
         $display("FAIL steps2 state=%h want 0006", st_s);
      end else pass_cnt++;
      total_cnt++;
      @(negedge clk);
      if (st_s !== 16'h0006) begin
         $display("FAIL steps2_hold state=%h want 0006", st_s);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_wrap4();
      logic [3:0]  seq [15];
      logic [15:0] visited;
      int          wraps;
      int          bad;
      seq     = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
      visited = '0;
      wraps   = 0;
      bad     = 0;
      en_w    = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         visited[st_w] = 1'b1;
         if (wrap_w === 1'b1) wraps++;
         if (st_w !== seq[(c - 1) % 15] || wrap_w !== (c % 15 == 0)) begin
            bad++;
            $display("FAIL w4_cycle[%0d] state=%h wrap=%b want %h %b", c, st_w, wrap_w, seq[(c - 1) % 15], (c % 15 == 0));
         end
         if (c == 15) begin
            if (per_w !== 4'd15) begin
               $display("FAIL w4_period_first period=%0d want 15", per_w);
            end else pass_cnt++;
            total_cnt++;
         end
      end
      en_w = 1'b0;
      if (bad != 0) begin
         $display("FAIL w4_sequence mismatched_cycles=%0d want 0", bad);
      end else pass_cnt++;
      total_cnt++;
      if (wraps != 2 || visited !== 16'hFFFE) begin
         $display("FAIL w4_wraps wraps=%0d visited=%h want 2 fffe", wraps, visited);
      end else pass_cnt++;
      total_cnt++;
      @(negedge clk);
      if (wrap_w !== 1'b0 || per_w !== 4'd15) begin
         $display("FAIL w4_idle wrap=%b period=%0d want 0 15", wrap_w, per_w);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_load_zero();
      load_f = 1'b1;
      lv_f   = 16'h0000;
      @(negedge clk);
      load_f = 1'b0;
      if (st_f !== 16'h8001 || lock_f !== 1'b1) begin
         $display("FAIL load_zero state=%h lock=%b want 8001 1", st_f, lock_f);
      end else pass_cnt++;
      total_cnt++;
      @(negedge clk);
      if (lock_f !== 1'b0 || st_f !== 16'h8001) begin
         $display("FAIL load_zero_pulse state=%h lock=%b want 8001 0", st_f, lock_f);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_load_priority();
      load_f = 1'b1;
      en_f   = 1'b1;
      lv_f   = 16'h1234;
      @(negedge clk);
      load_f = 1'b0;
      if (st_f !== 16'h1234 || wrap_f !== 1'b0 || lock_f !== 1'b0) begin
         $display("FAIL load_prio state=%h wrap=%b lock=%b want 1234 0 0", st_f, wrap_f, lock_f);
      end else pass_cnt++;
      total_cnt++;
      @(negedge clk);
      en_f = 1'b0;
      if (st_f !== 16'h2469) begin
         $display("FAIL load_then_step state=%h want 2469", st_f);
      end else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_reset_mid();
      en_w = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      if (st_w !== 4'h1 || wrap_w !== 1'b0 || per_w !== 4'h0 || st_f !== 16'h8001) begin
         $display("FAIL reset_mid_async w4=%h wrap=%b period=%h fib=%h want 1 0 0 8001", st_w, wrap_w, per_w, st_f);
      end else pass_cnt++;
      total_cnt++;
      repeat (3) @(negedge clk);
      if (st_w !== 4'h1 || per_w !== 4'h0) begin
         $display("FAIL reset_mid_hold w4=%h period=%h want 1 0", st_w, per_w);
      end else pass_cnt++;
      total_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      en_w = 1'b0;
      if (st_w !== 4'h2) begin
         $display("FAIL reset_mid_resume w4=%h want 2", st_w);
      end else pass_cnt++;
      total_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n  = 1'b0;
      en_f   = 1'b0; load_f = 1'b0; lv_f = '0;
      en_g   = 1'b0; load_g = 1'b0; lv_g = '0;
      en_s   = 1'b0; load_s = 1'b0; lv_s = '0;
      en_w   = 1'b0; load_w = 1'b0; lv_w = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_fib();
      test_galois();
      test_steps2();
      test_wrap4();
      test_load_zero();
      test_load_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised LFSR pseudo-random generator; successor to the fixed 16-bit Fibonacci LFSR.
- Adds:
  - generic width, tap mask and seed;
  - Fibonacci or Galois mode;
  - multiple shifts per clock;
  - enable and runtime seed load;
  - all-zero lock-up protection;
  - sequence-wrap detection with measured period.
- Serves as the pattern/noise source for BIST and test-stimulus paths in the digital-circuits library.

Parameters:
- WIDTH, 16, state width in bits; legal range 3..32.
- TAPS, 16'hB400, Fibonacci tap mask; bit i set means state[i] feeds the XOR. Default is x^16+x^14+x^13+x^11+1. TAPS[WIDTH-1] must be 1.
- SEED, 16'h8001, reset and fallback state; must be nonzero (elaboration-time assertion).
- MODE, 0, 0 = Fibonacci, 1 = Galois.
- STEPS, 1, single-steps applied per enabled cycle; legal range 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance state by STEPS single-steps this cycle
- load  in  1  load load_val this cycle; has priority over en
- load_val  in  WIDTH  seed to load
- state_out  out  WIDTH  current LFSR state (registered)
- bit_out  out  1  state_out[WIDTH-1]
- wrap  out  1  one-cycle pulse: state returned to the last-loaded seed
- period  out  WIDTH  step count of the last completed wrap
- lock_err  out  1  one-cycle pulse: zero load rejected

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous assert, synchronous release; active low.
- Reset values:
  - state = SEED; ref_seed = SEED.
  - step_cnt = 0, period = 0, wrap = 0, lock_err = 0.
- Fibonacci single-step:
  - fb = XOR of state[i] over all i with TAPS[i] = 1.
  - next = {state[WIDTH-2:0], fb}.
- Galois single-step:
  - GMASK = {TAPS[WIDTH-2:0], 1'b1}.
  - next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & GMASK).
- Per-cycle update:
  - When en = 1 and load = 0, the single-step is applied STEPS times combinationally, unrolled.
  - Result registers next edge; latency is 1 cycle from en to state_out.
- load = 1:
  - If load_val != 0: state <= load_val; ref_seed <= load_val.
  - If load_val == 0: state <= SEED; ref_seed <= SEED; lock_err pulses 1 next cycle.
  - In both cases step_cnt <= 0 and wrap stays 0.
  - en is ignored in a load cycle.
- en = 0 and load = 0: all registers hold; wrap and lock_err drop to 0.
- Step counter:
  - step_cnt adds STEPS on each enabled step.
  - Counter width is WIDTH+1 bits; it wraps modulo 2^(WIDTH+1).
- Wrap detection:
  - If the post-step state equals ref_seed: wrap pulses 1 next cycle.
  - period <= step_cnt + STEPS, truncated to WIDTH bits.
  - step_cnt <= 0.
  - Only end-of-cycle states are compared; with STEPS > 1 intermediate states are not checked.
- Lock-up: the state can never become zero. Zero is blocked at load, and valid taps never reach zero from a nonzero state.
- Reset asserted mid-run: all registers return to reset values immediately; any pending pulses are lost.

Decomposition:
- Package lfsr_pkg:
  - lfsr_mode_e enum: LFSR_FIB, LFSR_GAL.
  - Function lfsr_step(state, taps, mode): one single-step, usable in RTL and in the scoreboard.
  - Default tap constants: TAPS_4 = 4'hC, TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_32 = 32'h80200003.
- Sub-module lfsr_step_net: purely combinational STEPS-deep unrolled chain of lfsr_step; the top holds the registers, counter and control.

Test Plan:
- Reset release, defaults, en = 1 -> state_out sequence 0x8001, 0x0003, 0x0006; bit_out = 1, 0, 0.
- MODE = 1, defaults, en = 1 -> 0x8001, 0x6803, 0xD006.
- STEPS = 2, MODE = 0, en = 1 for one cycle -> state 0x8001 then 0x0006.
- WIDTH = 4, TAPS = 4'hC, SEED = 1, en held high -> wrap pulses once every 15 cycles; period = 15 after the first wrap; all 15 nonzero states are visited.
- Load tests:
  - load = 1 with load_val = 0 -> state 0x8001, lock_err high for 1 cycle.
  - load = 1 and en = 1 with load_val = 0x1234 -> state 0x1234, no step taken.
- Reset mid-run: assert rst_n low for 3 cycles mid-sequence -> state 0x8001, wrap = 0, period = 0 immediately, without waiting for a clock.
